// File: rtl/prio_decoder_latch_if.sv
// prio_decoder_latch_if
//  Event/bitmap bundle between the event parser and the held-line decoder.
//  master : drives ev_stb/ev_on/ev_idx/all_off/sustain, observes lines/count/any/changed
//  slave  : the decoder (prio_decoder_latch)
interface prio_decoder_latch_if #(
    parameter int LINES = 128,
    parameter int WIDTH = $clog2(LINES)
) ();
    logic             ev_stb;
    logic             ev_on;
    logic [WIDTH-1:0] ev_idx;
    logic             all_off;
    logic             sustain;
    logic [LINES-1:0] lines;
    logic [WIDTH:0]   count;
    logic             any;
    logic             changed;

    modport master (
        output ev_stb, ev_on, ev_idx, all_off, sustain,
        input  lines, count, any, changed
    );

    modport slave (
        input  ev_stb, ev_on, ev_idx, all_off, sustain,
        output lines, count, any, changed
    );
endinterface

// File: rtl/prio_decoder_latch.sv
// prio_decoder_latch
//  Turns indexed key events (index + on/off strobe) into a registered held-line
//  bitmap, plus a registered popcount, an any-held flag and a change pulse.
//  Optional feature macro: SUSTAIN_EN (sustain pedal holds released lines).
// Ports
//  clk   : system clock, rising edge
//  rst_n : asynchronous active-low reset
//  bus   : prio_decoder_latch_if.slave
//          in : ev_stb, ev_on, ev_idx, all_off, sustain
//          out: lines (held bitmap), count (popcount), any, changed (1-cycle pulse)
module prio_decoder_latch #(
    parameter int LINES = 128,
    parameter int WIDTH = $clog2(LINES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    prio_decoder_latch_if.slave   bus
);
    localparam logic [WIDTH:0] LINES_W = LINES[WIDTH:0];

    logic [LINES-1:0] key_q, key_nxt;
    logic [LINES-1:0] lines_q, lines_nxt;
    logic [LINES-1:0] dec;
    logic [WIDTH:0]   cnt_q, cnt_nxt;
    logic             any_q, chg_q;
    logic             idx_ok;

    // Indices past LINES can only occur when LINES is not a power of two.
    assign idx_ok = ({1'b0, bus.ev_idx} < LINES_W);

    always_comb begin
        dec = '0;
        if (idx_ok) dec[bus.ev_idx] = 1'b1;
    end

`ifdef SUSTAIN_EN
    logic [LINES-1:0] sus_q, sus_nxt;
    logic             sus_r, sus_fall, pedal_dn;

    assign sus_fall = sus_r & ~bus.sustain;
    // During the release cycle the pedal counts as up, so an off event
    // in that cycle really drops the line.
    assign pedal_dn = sus_r & bus.sustain;

    always_comb begin
        key_nxt = key_q;
        sus_nxt = sus_fall ? '0 : sus_q;
        if (bus.all_off) begin
            key_nxt = '0;
            sus_nxt = '0;
        end else if (bus.ev_stb && idx_ok) begin
            if (bus.ev_on) begin
                key_nxt = key_q | dec;
                sus_nxt = sus_nxt & ~dec;
            end else begin
                key_nxt = key_q & ~dec;
                // Only a line actually held moves into the sustained set.
                if (pedal_dn) sus_nxt = sus_nxt | (dec & key_q);
            end
        end
        lines_nxt = key_nxt | sus_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sus_q <= '0;
            sus_r <= 1'b0;
        end else begin
            sus_q <= sus_nxt;
            sus_r <= bus.sustain;
        end
    end
`else
    logic unused_sustain;
    assign unused_sustain = bus.sustain;

    always_comb begin
        key_nxt = key_q;
        if (bus.all_off)
            key_nxt = '0;
        else if (bus.ev_stb && idx_ok)
            key_nxt = bus.ev_on ? (key_q | dec) : (key_q & ~dec);
        lines_nxt = key_nxt;
    end
`endif

    // Count is taken from the next bitmap so it tracks lines in the same cycle.
    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < LINES; i++)
            cnt_nxt = cnt_nxt + {{WIDTH{1'b0}}, lines_nxt[i]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q   <= '0;
            lines_q <= '0;
            cnt_q   <= '0;
            any_q   <= 1'b0;
            chg_q   <= 1'b0;
        end else begin
            key_q   <= key_nxt;
            lines_q <= lines_nxt;
            cnt_q   <= cnt_nxt;
            any_q   <= (cnt_nxt != '0);
            chg_q   <= (lines_nxt != lines_q);
        end
    end

    assign bus.lines   = lines_q;
    assign bus.count   = cnt_q;
    assign bus.any     = any_q;
    assign bus.changed = chg_q;
endmodule

// File: tb/tb_prio_decoder_latch.sv
module tb_prio_decoder_latch;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    prio_decoder_latch_if #(.LINES(128), .WIDTH(7)) a ();
    prio_decoder_latch_if #(.LINES(100), .WIDTH(7)) b ();

    prio_decoder_latch #(.LINES(128), .WIDTH(7)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a.slave));
    prio_decoder_latch #(.LINES(100), .WIDTH(7)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b.slave));

    logic [127:0] exp_a;
    logic [99:0]  exp_b;

    // Drive one event into DUT A over one cycle; returns at the following negedge.
    task automatic ev_a(input logic on, input int idx, input logic off_all);
        a.ev_stb  = 1'b1;
        a.ev_on   = on;
        a.ev_idx  = 7'(idx);
        a.all_off = off_all;
        @(negedge clk);
        a.ev_stb  = 1'b0;
        a.all_off = 1'b0;
    endtask

    task automatic ev_b(input logic on, input int idx);
        b.ev_stb = 1'b1;
        b.ev_on  = on;
        b.ev_idx = 7'(idx);
        @(negedge clk);
        b.ev_stb = 1'b0;
    endtask

    task automatic test_reset;
        n_cmp++;
        if (a.lines !== '0 || a.count !== 8'd0 || a.any !== 1'b0 || a.changed !== 1'b0) begin
            n_err++;
            $display("FAIL reset: lines=%h count=%0d any=%b chg=%b want all 0", a.lines, a.count, a.any, a.changed);
        end
    endtask

    task automatic test_single_on;
        ev_a(1'b1, 60, 1'b0);
        exp_a = '0; exp_a[60] = 1'b1;
        n_cmp++;
        if (a.lines !== exp_a) begin n_err++; $display("FAIL on60 lines: got %h want %h", a.lines, exp_a); end
        n_cmp++;
        if (a.count !== 8'd1 || a.any !== 1'b1) begin n_err++; $display("FAIL on60 count/any: got %0d/%b want 1/1", a.count, a.any); end
        n_cmp++;
        if (a.changed !== 1'b1) begin n_err++; $display("FAIL on60 changed: got %b want 1", a.changed); end
        @(negedge clk);
        n_cmp++;
        if (a.changed !== 1'b0) begin n_err++; $display("FAIL on60 changed drop: got %b want 0", a.changed); end
    endtask

    task automatic test_repeat_on;
        ev_a(1'b1, 60, 1'b0);
        n_cmp++;
        if (a.count !== 8'd1 || a.changed !== 1'b0) begin
            n_err++; $display("FAIL repeat on: count=%0d chg=%b want 1/0", a.count, a.changed);
        end
    endtask

    task automatic test_bounds;
        ev_a(1'b0, 0, 1'b1);
        n_cmp++;
        if (a.lines !== '0 || a.changed !== 1'b1) begin n_err++; $display("FAIL clear: lines=%h chg=%b want 0/1", a.lines, a.changed); end
        ev_a(1'b1, 0, 1'b0);
        ev_a(1'b1, 127, 1'b0);
        n_cmp++;
        if (a.count !== 8'd2) begin n_err++; $display("FAIL on0+127 count: got %0d want 2", a.count); end
        ev_a(1'b0, 0, 1'b0);
        exp_a = '0; exp_a[127] = 1'b1;
        n_cmp++;
        if (a.lines !== exp_a || a.count !== 8'd1) begin n_err++; $display("FAIL off0: lines=%h count=%0d want %h/1", a.lines, a.count, exp_a); end
        ev_a(1'b0, 5, 1'b0);
        n_cmp++;
        if (a.lines !== exp_a || a.changed !== 1'b0 || a.count !== 8'd1) begin
            n_err++; $display("FAIL off5: lines=%h chg=%b count=%0d want %h/0/1", a.lines, a.changed, a.count, exp_a);
        end
    endtask

    task automatic test_back_to_back_all_off;
        ev_a(1'b1, 10, 1'b0);
        ev_a(1'b1, 20, 1'b0);
        ev_a(1'b1, 30, 1'b0);
        exp_a = '0; exp_a[127] = 1'b1; exp_a[10] = 1'b1; exp_a[20] = 1'b1; exp_a[30] = 1'b1;
        n_cmp++;
        if (a.lines !== exp_a || a.count !== 8'd4) begin n_err++; $display("FAIL b2b: lines=%h count=%0d want %h/4", a.lines, a.count, exp_a); end
        ev_a(1'b1, 40, 1'b1);
        n_cmp++;
        if (a.lines !== '0 || a.count !== 8'd0 || a.any !== 1'b0) begin
            n_err++; $display("FAIL all_off: lines=%h count=%0d any=%b want 0/0/0", a.lines, a.count, a.any);
        end
        n_cmp++;
        if (a.changed !== 1'b1) begin n_err++; $display("FAIL all_off changed: got %b want 1", a.changed); end
    endtask

`ifdef SUSTAIN_EN
    task automatic test_sustain;
        a.sustain = 1'b1;
        @(negedge clk);
        ev_a(1'b1, 64, 1'b0);
        ev_a(1'b0, 64, 1'b0);
        exp_a = '0; exp_a[64] = 1'b1;
        n_cmp++;
        if (a.lines !== exp_a || a.count !== 8'd1) begin n_err++; $display("FAIL sus hold: lines=%h count=%0d want %h/1", a.lines, a.count, exp_a); end
        a.sustain = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (a.lines !== '0 || a.count !== 8'd0 || a.changed !== 1'b1) begin
            n_err++; $display("FAIL sus release: lines=%h count=%0d chg=%b want 0/0/1", a.lines, a.count, a.changed);
        end
    endtask
`endif

    task automatic test_out_of_range;
        ev_b(1'b1, 120);
        n_cmp++;
        if (b.lines !== '0 || b.count !== 8'd0 || b.changed !== 1'b0) begin
            n_err++; $display("FAIL oob 120: lines=%h count=%0d chg=%b want 0/0/0", b.lines, b.count, b.changed);
        end
        ev_b(1'b1, 99);
        exp_b = '0; exp_b[99] = 1'b1;
        n_cmp++;
        if (b.lines !== exp_b || b.count !== 8'd1 || b.any !== 1'b1) begin
            n_err++; $display("FAIL top 99: lines=%h count=%0d any=%b want %h/1/1", b.lines, b.count, b.any, exp_b);
        end
    endtask

    task automatic test_reset_mid;
        ev_a(1'b1, 3, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (a.lines !== '0 || a.count !== 8'd0 || a.any !== 1'b0 || a.changed !== 1'b0 || b.lines !== '0 || b.count !== 8'd0) begin
            n_err++; $display("FAIL mid reset: a=%h/%0d/%b/%b b=%h/%0d want 0", a.lines, a.count, a.any, a.changed, b.lines, b.count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ev_a(1'b1, 7, 1'b0);
        exp_a = '0; exp_a[7] = 1'b1;
        n_cmp++;
        if (a.lines !== exp_a || a.count !== 8'd1 || a.changed !== 1'b1) begin
            n_err++; $display("FAIL after reset: lines=%h count=%0d chg=%b want %h/1/1", a.lines, a.count, a.changed, exp_a);
        end
    endtask

    initial begin
        a.ev_stb = 1'b0; a.ev_on = 1'b0; a.ev_idx = '0; a.all_off = 1'b0; a.sustain = 1'b0;
        b.ev_stb = 1'b0; b.ev_on = 1'b0; b.ev_idx = '0; b.all_off = 1'b0; b.sustain = 1'b0;
        @(negedge clk);
        @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        @(negedge clk);
        test_single_on;
        test_repeat_on;
        test_bounds;
        test_back_to_back_all_off;
`ifdef SUSTAIN_EN
        test_sustain;
`endif
        test_out_of_range;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
